// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, memory-wait freeze and timeout.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned WAIT_MAX     = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_regwr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned BUB_W  = 2;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    ERR        = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BUB_W-1:0]    bub_cnt_q, bub_cnt_d;

  logic load_use_c;
  logic mem_wait_c;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_en_c;

  always_comb begin
    load_use_c = ex_memtoreg & ex_regwr & (ex_rt != 5'd0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
    mem_wait_c = mem_req & ~mem_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      bub_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bub_cnt_q  <= bub_cnt_d;
    end
  end

  // Next state and raw pipeline controls; the memory freeze outranks everything.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    bub_cnt_d    = bub_cnt_q;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_en_c    = 1'b1;
    idex_flush_c = 1'b0;
    exmem_en_c   = 1'b1;

    case (state_q)
      RUN: begin
        if (mem_wait_c) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          wait_cnt_d = WAIT_W'(1);
          state_d    = (WAIT_MAX <= 1) ? ERR : MEM_WAIT;
        end else if (ex_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (load_use_c) begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            bub_cnt_d = BUB_W'(LOAD_BUBBLES - 1);
            state_d   = LOAD_STALL;
          end
        end
      end

      LOAD_STALL: begin
        if (mem_wait_c) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          wait_cnt_d = WAIT_W'(1);
          bub_cnt_d  = '0;
          state_d    = (WAIT_MAX <= 1) ? ERR : MEM_WAIT;
        end else begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
          bub_cnt_d    = bub_cnt_q - BUB_W'(1);
          if (bub_cnt_q <= BUB_W'(1)) begin
            state_d = RUN;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_ack) begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q >= WAIT_W'(WAIT_MAX - 1)) begin
            state_d = ERR;
          end
        end
      end

      ERR: begin
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Reset holds the pipeline frozen with both front registers cleared.
  always_comb begin
    pc_en      = ~rst & pc_en_c;
    ifid_en    = ~rst & ifid_en_c;
    idex_en    = ~rst & idex_en_c;
    exmem_en   = ~rst & exmem_en_c;
    ifid_flush = rst | ifid_flush_c;
    idex_flush = rst | idex_flush_c;
    busy       = ~rst & (state_q != RUN);
    err        = ~rst & (state_q == ERR);
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; ifid_flush_c is only raised by a branch flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with 1 load bubble, one with 3, shared inputs.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, busy, err}
  localparam logic [7:0] RSTV = 8'b0010_1000;
  localparam logic [7:0] RUNV = 8'b1101_0100;
  localparam logic [7:0] BRV  = 8'b1111_1100;
  localparam logic [7:0] LUV  = 8'b0001_1100;
  localparam logic [7:0] LSV  = 8'b0001_1110;
  localparam logic [7:0] MW0  = 8'b0000_0000;
  localparam logic [7:0] MWV  = 8'b0000_0010;
  localparam logic [7:0] ACKV = 8'b1101_0110;
  localparam logic [7:0] ERRV = 8'b0000_0011;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_memtoreg, ex_regwr, ex_branch_taken, mem_req, mem_ack;

  logic pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1, busy1, err1;
  logic pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3, exmem_en3, busy3, err3;
  logic [15:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
  logic [7:0] v1, v3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1), .WAIT_MAX(15), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_memtoreg(ex_memtoreg), .ex_regwr(ex_regwr), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_en(idex_en1),
    .idex_flush(idex_flush1), .exmem_en(exmem_en1), .busy(busy1), .err(err1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .WAIT_MAX(15), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_memtoreg(ex_memtoreg), .ex_regwr(ex_regwr), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3), .idex_en(idex_en3),
    .idex_flush(idex_flush3), .exmem_en(exmem_en3), .busy(busy3), .err(err3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  assign v1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1, busy1, err1};
  assign v3 = {pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3, exmem_en3, busy3, err3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_memtoreg = 1'b0; ex_regwr = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rt, input logic [4:0] rs_id, input logic [4:0] rt_id);
    ex_memtoreg = 1'b1; ex_regwr = 1'b1; ex_rt = rt; id_rs = rs_id; id_rt = rt_id;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("rst_v1", 32'(v1), 32'(RSTV));
    chk("rst_v3", 32'(v3), 32'(RSTV));
    chk("rst_stall1", 32'(stall_cnt1), 32'd0);
    chk("rst_flush1", 32'(flush_cnt1), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_v1", 32'(v1), 32'(RUNV));
    chk("idle_v3", 32'(v3), 32'(RUNV));

    // Load-use on Rs: 1 bubble vs 3 bubbles
    load_use(5'd5, 5'd5, 5'd0);
    #1;
    chk("lu_c1_v1", 32'(v1), 32'(LUV));
    chk("lu_c1_v3", 32'(v3), 32'(LUV));
    tick();
    idle();
    #1;
    chk("lu_c2_v1", 32'(v1), 32'(RUNV));
    chk("lu_c2_v3", 32'(v3), 32'(LSV));
    tick();
    #1;
    chk("lu_c3_v1", 32'(v1), 32'(RUNV));
    chk("lu_c3_v3", 32'(v3), 32'(LSV));
    tick();
    #1;
    chk("lu_done_v3", 32'(v3), 32'(RUNV));

    // r0 never hazards; no RegWr never hazards
    load_use(5'd0, 5'd0, 5'd0);
    #1;
    chk("rt0_v1", 32'(v1), 32'(RUNV));
    ex_rt = 5'd7; id_rt = 5'd7; ex_regwr = 1'b0;
    #1;
    chk("noregwr_v1", 32'(v1), 32'(RUNV));
    // Hazard through Rt
    ex_regwr = 1'b1;
    #1;
    chk("lu_rt_v1", 32'(v1), 32'(LUV));
    tick();
    idle();
    tick();
    tick();
    #1;
    chk("lu_rt_drain_v1", 32'(v1), 32'(RUNV));
    chk("lu_rt_drain_v3", 32'(v3), 32'(RUNV));

    // Branch together with load-use: branch wins
    load_use(5'd9, 5'd9, 5'd9);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_v1", 32'(v1), 32'(BRV));
    chk("br_v3", 32'(v3), 32'(BRV));
    tick();
    idle();
    #1;
    chk("br_after_v1", 32'(v1), 32'(RUNV));
    chk("br_after_v3", 32'(v3), 32'(RUNV));
    chk("flush_cnt1", 32'(flush_cnt1), PERF ? 32'd1 : 32'd0);
    chk("stall_cnt1_a", 32'(stall_cnt1), PERF ? 32'd2 : 32'd0);
    chk("stall_cnt3_a", 32'(stall_cnt3), PERF ? 32'd6 : 32'd0);

    // Synchronous-style reset pulse clears counters
    rst = 1'b1;
    #1;
    chk("rst2_v1", 32'(v1), 32'(RSTV));
    chk("rst2_flush1", 32'(flush_cnt1), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_stall1", 32'(stall_cnt1), 32'd0);

    // Memory wait for 4 cycles then ack
    mem_req = 1'b1;
    #1;
    chk("mw_c1_v1", 32'(v1), 32'(MW0));
    chk("mw_c1_v3", 32'(v3), 32'(MW0));
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("mw_wait_v1", 32'(v1), 32'(MWV));
    end
    tick();
    mem_ack = 1'b1;
    #1;
    chk("mw_ack_v1", 32'(v1), 32'(ACKV));
    chk("mw_ack_v3", 32'(v3), 32'(ACKV));
    tick();
    idle();
    #1;
    chk("mw_after_v1", 32'(v1), 32'(RUNV));
    chk("mw_stall_cnt1", 32'(stall_cnt1), PERF ? 32'd4 : 32'd0);

    // Memory wait preempts an in-progress load stall
    load_use(5'd3, 5'd3, 5'd0);
    tick();
    idle();
    mem_req = 1'b1;
    #1;
    chk("pre_v1", 32'(v1), 32'(MW0));
    chk("pre_v3", 32'(v3), 32'(MWV));
    tick();
    chk("pre_wait_v3", 32'(v3), 32'(MWV));
    mem_ack = 1'b1;
    #1;
    chk("pre_ack_v3", 32'(v3), 32'(ACKV));
    tick();
    idle();
    #1;
    chk("pre_run_v3", 32'(v3), 32'(RUNV));

    // Asynchronous reset between edges during a load stall
    load_use(5'd4, 5'd0, 5'd4);
    tick();
    idle();
    #1;
    chk("ar_ls_v3", 32'(v3), 32'(LSV));
    rst = 1'b1;
    #1;
    chk("ar_ls_rst_v3", 32'(v3), 32'(RSTV));
    rst = 1'b0;
    #1;
    chk("ar_ls_rel_v3", 32'(v3), 32'(RUNV));

    // Asynchronous reset between edges during a memory wait
    tick();
    mem_req = 1'b1;
    tick();
    chk("ar_mw_v1", 32'(v1), 32'(MWV));
    rst = 1'b1;
    #1;
    chk("ar_mw_rst_v1", 32'(v1), 32'(RSTV));
    mem_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("ar_mw_rel_v1", 32'(v1), 32'(RUNV));
    chk("ar_mw_rel_v3", 32'(v3), 32'(RUNV));

    // Timeout: 15 frozen cycles, then sticky ERR
    tick();
    mem_req = 1'b1;
    #1;
    chk("to_c1_v1", 32'(v1), 32'(MW0));
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk("to_wait_v1", 32'(v1), 32'(MWV));
    end
    tick();
    chk("to_err_v1", 32'(v1), 32'(ERRV));
    chk("to_err_v3", 32'(v3), 32'(ERRV));
    mem_ack = 1'b1;
    #1;
    chk("to_err_ack_v1", 32'(v1), 32'(ERRV));
    tick();
    tick();
    chk("to_err_hold_v1", 32'(v1), 32'(ERRV));
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("to_rst_v1", 32'(v1), 32'(RSTV));
    chk("to_rst_stall1", 32'(stall_cnt1), 32'd0);
    chk("to_rst_flush1", 32'(flush_cnt1), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("to_run_v1", 32'(v1), 32'(RUNV));
    chk("to_run_v3", 32'(v3), 32'(RUNV));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_BUBBLES, default 1, number of bubbles inserted per load-use hazard (legal 1..3).
REQ-002 SHALL have parameter WAIT_MAX, default 15, maximum MEM_WAIT cycles before timeout (legal 1..255).
REQ-003 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-004 Ports, in this order:
- clk  in  1  single clock; state updates on posedge; pipeline registers sample on negedge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  Rs of the instruction in IF/ID.
- id_rt  in  5  Rt of the instruction in IF/ID.
- ex_rt  in  5  Rt_out of ID/EX.
- ex_memtoreg  in  1  MemtoReg_out of ID/EX (load in EX).
- ex_regwr  in  1  RegWr_out of ID/EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage data access pending.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX clear: all control outputs zero, i.e. a bubble.
- exmem_en  out  1  EX/MEM load enable.
- busy  out  1  state is not RUN.
- err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  stall-cycle count.
- flush_cnt  out  CNT_W  branch-flush count.

Function
REQ-005 SHALL implement the FSM states RUN, LOAD_STALL, MEM_WAIT and ERR, registered on posedge clk; outputs SHALL be combinational from state and inputs.
REQ-006 In RUN with no event, all enables SHALL be 1 and both flushes SHALL be 0.
REQ-007 A load-use hazard SHALL be ex_memtoreg & ex_regwr & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-008 Event priority in RUN SHALL be: memory wait, then branch, then load-use.
REQ-009 Memory wait (mem_req & ~mem_ack) in RUN SHALL:
- drive pc_en, ifid_en, idex_en and exmem_en to 0 in the same cycle;
- move to MEM_WAIT with wait counter = 1.
REQ-010 In MEM_WAIT:
- all enables SHALL stay 0.
- On mem_ack, all enables SHALL be 1 in that cycle and the next state SHALL be RUN.
- Otherwise the wait counter SHALL increment.
- Reaching WAIT_MAX without ack SHALL move to ERR.
REQ-011 In MEM_WAIT, ex_branch_taken and load-use SHALL be ignored; they are re-evaluated in RUN because EX is frozen.
REQ-012 A taken branch in RUN without memory wait SHALL assert ifid_flush=1 and idex_flush=1 for exactly that cycle, keep all enables 1, and stay in RUN (branch penalty 2 bubbles).
REQ-013 A load-use hazard in RUN without a higher-priority event SHALL drive pc_en=0, ifid_en=0, idex_flush=1 and exmem_en=1.
- If LOAD_BUBBLES > 1, it SHALL move to LOAD_STALL with remaining count LOAD_BUBBLES-1.
- Otherwise it SHALL stay in RUN.
REQ-014 In LOAD_STALL:
- outputs SHALL equal those of REQ-013;
- the count SHALL decrement each cycle;
- the state SHALL return to RUN on the cycle the count reaches 0;
- memory wait SHALL preempt to MEM_WAIT, and the remaining bubbles SHALL be discarded.
REQ-015 Branch and load-use in the same cycle SHALL produce branch behaviour only.
REQ-016 In ERR:
- all enables SHALL be 0 and both flushes 0;
- err SHALL be 1 until rst.
REQ-017 busy SHALL be 1 in LOAD_STALL, MEM_WAIT and ERR.

Reset
REQ-018 While rst=1:
- state SHALL be RUN, and all counters and err SHALL be 0;
- pc_en, ifid_en, idex_en and exmem_en SHALL be 0;
- ifid_flush and idex_flush SHALL be 1;
- busy SHALL be 0.
REQ-019 Asserting rst mid-LOAD_STALL or mid-MEM_WAIT SHALL abort immediately without waiting for a clock edge; after release the block SHALL start in RUN.

Configuration
REQ-020 With macro HAZARD_PERF_EN defined, the performance counters SHALL be active:
- stall_cnt SHALL increment each posedge with pc_en=0 outside reset;
- flush_cnt SHALL increment per branch-flush cycle;
- both SHALL saturate at all-ones.
REQ-021 Without HAZARD_PERF_EN, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL be implemented.

Verification
REQ-022 ex_memtoreg=1, ex_regwr=1, ex_rt=5, id_rs=5, LOAD_BUBBLES=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then RUN with all enables 1.
REQ-023 Same hazard with ex_rt=0 -> no stall; with LOAD_BUBBLES=3 -> 3 consecutive stall cycles, busy=1 for cycles 2-3.
REQ-024 ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_en=1 for one cycle; with HAZARD_PERF_EN, flush_cnt 0->1.
REQ-025 mem_req=1, mem_ack=0 for 4 cycles then mem_ack=1 -> enables 0 for 4 cycles, then 1 on the ack cycle; with HAZARD_PERF_EN, stall_cnt=4.
REQ-026 mem_req=1 with no ack, WAIT_MAX=15 -> ERR after 15 cycles, err=1 and held; rst pulse mid-ERR -> err=0, state RUN, counters 0.
